// File: rtl/spart_pkg.sv
// Register-select map and driver state encoding shared by spart and spart_driver.
package spart_pkg;

    localparam logic [1:0] REGSELECT_TXRXBUF = 2'b00;
    localparam logic [1:0] REGSELECT_STAT    = 2'b01;
    localparam logic [1:0] REGSELECT_DBL     = 2'b10;
    localparam logic [1:0] REGSELECT_DBH     = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT_DBL = 3'd0,
        ST_INIT_DBH = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RX_RD    = 3'd3,
        ST_TX_WAIT  = 3'd4,
        ST_TX_WR    = 3'd5
    } drv_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; reset loads both stages straight from the input.
module sync2 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        meta <= d;
        if (rst) begin
            q <= d;
        end else begin
            q <= meta;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// Processor stand-in for one spart: programs the baud divisor from switches, then echoes RX to TX.
//
// state        | meaning
// INIT_DBL     | write low divisor byte
// INIT_DBH     | write high divisor byte
// IDLE         | reprogram on switch change, else start echo on rda
// RX_RD        | read RX buffer
// TX_WAIT      | wait for tbr
// TX_WR        | write echoed byte to TX buffer
module spart_driver
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_4800  = 16'd650,
    parameter logic [15:0] DIV_9600  = 16'd325,
    parameter logic [15:0] DIV_19200 = 16'd162,
    parameter logic [15:0] DIV_38400 = 16'd80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    drv_state_e  state;
    logic [1:0]  br_sync;
    logic [1:0]  br_cur;
    logic [7:0]  rx_byte;
    logic [7:0]  dout;
    logic [15:0] div;

    sync2 #(.WIDTH(2)) u_br_sync (
        .clk (clk),
        .rst (rst),
        .d   (br_cfg),
        .q   (br_sync)
    );

    always_comb begin
        div = DIV_9600;
        case (br_cur)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
    end

    assign databus = (iocs && !iorw) ? dout : 8'hzz;

    // Bus outputs are registered: a state's access appears on the bus for the cycle after its edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT_DBL;
            iocs    <= 1'b0;
            iorw    <= 1'b1;
            ioaddr  <= REGSELECT_TXRXBUF;
            dout    <= 8'h00;
            rx_byte <= 8'h00;
            br_cur  <= br_cfg;
        end else begin
            iocs   <= 1'b0;
            iorw   <= 1'b1;
            ioaddr <= REGSELECT_TXRXBUF;

            // The SPART presents RX data during the read strobe cycle.
            if (iocs && iorw && (ioaddr == REGSELECT_TXRXBUF)) begin
                rx_byte <= databus;
            end

            case (state)
                ST_INIT_DBL: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= REGSELECT_DBL;
                    dout   <= div[7:0];
                    state  <= ST_INIT_DBH;
                end
                ST_INIT_DBH: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= REGSELECT_DBH;
                    dout   <= div[15:8];
                    state  <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (br_sync != br_cur) begin
                        br_cur <= br_sync;
                        state  <= ST_INIT_DBL;
                    end else if (rda) begin
                        state <= ST_RX_RD;
                    end
                end
                ST_RX_RD: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b1;
                    ioaddr <= REGSELECT_TXRXBUF;
                    state  <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (tbr) begin
                        state <= ST_TX_WR;
                    end
                end
                ST_TX_WR: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= REGSELECT_TXRXBUF;
                    dout   <= rx_byte;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
